spi_req_scheduler: RTL
======================

// Module: spi_req_scheduler
// PURPOSE
//  Shares one 16-bit SPI master between NUM_REQ requesters (gate-driver/ADC tasks) with a round-robin scheduler.
//  Grants one requester at a time, launches the SPI transfer, returns the received word and enforces an idle CS gap between frames.
//  Sits between the application FSMs and the SPI master; it is the only block that drives the master's start_transfer and data_to_tx.
// PARAMETERS
//  NUM_REQ        4     number of requesters (2..8)
//  DATA_W         16    SPI word width
//  GAP_CYCLES     4     clk cycles idle between end of one transfer and the next launch (0 allowed)
//  TIMEOUT_CYCLES 4096  max cycles waiting for spi_done (used only with SPI_SCHED_TIMEOUT_EN)
// PORTS
//  clk          in   1               system clock (24 MHz HFOSC)
//  reset        in   1               synchronous, active-high
//  req          in   NUM_REQ         level request per requester; hold until own done pulse
//  req_data     in   NUM_REQ*DATA_W  word to send; slice i belongs to req[i]
//  grant        out  NUM_REQ         one-hot, high from launch cycle through done-pulse cycle
//  done         out  NUM_REQ         1-cycle pulse to the granted requester at end of transfer
//  rx_data      out  DATA_W          word received; valid in done-pulse cycle, held until next done
//  busy         out  1               high in any state other than IDLE
//  spi_start    out  1               to SPI master start_transfer; 1-cycle pulse
//  spi_tx_data  out  DATA_W          to SPI master data_to_tx; held stable from launch to end of transfer
//  spi_rx_data  in   DATA_W          from SPI master data_rx
//  spi_done     in   1               from SPI master, 1-cycle pulse when CS deasserts
//  timeout_err  out  1               1-cycle pulse with done when transfer aborted (tied 0 without macro)
// BEHAVIOUR
//  Reset: grant=0, done=0, rx_data=0, busy=0, spi_start=0, spi_tx_data=0, timeout_err=0; state=IDLE;
//   rr pointer so req[0] has highest priority first. Reset mid-transfer abandons it silently (no done pulse).
//  FSM: IDLE -> LAUNCH -> WAIT_DONE -> GAP -> IDLE (GAP skipped when GAP_CYCLES=0).
//  IDLE: cycle n any req bit high -> pick first set bit at/after rr pointer (wrap mod NUM_REQ);
//   latch its req_data into spi_tx_data; rr pointer := winner+1 (wrap). No req -> stay.
//  LAUNCH (n+1): grant[winner]=1, spi_start=1 (this cycle only); -> WAIT_DONE. spi_done here is ignored.
//  WAIT_DONE: spi_done at cycle m -> cycle m+1: rx_data:=spi_rx_data (sampled at m), done[winner]=1, grant held;
//   cycle m+2: grant=0, enter GAP.
//  GAP: count GAP_CYCLES cycles with busy=1, then IDLE; new arbitration in the IDLE cycle after.
//  Requester dropping req after grant: transfer completes, done still pulses; no re-grant unless req high again.
//  req_data changes after launch are ignored. grant/done never have more than one bit set.
//  Fairness: a continuously requesting set is served strictly in rotation; max wait = (NUM_REQ-1) transfers.
// CONFIGURATION
//  SPI_SCHED_TIMEOUT_EN defined: WAIT_DONE counter reset at LAUNCH; reaching TIMEOUT_CYCLES without spi_done ->
//   next cycle done[winner]=1, timeout_err=1, rx_data:=0, then GAP as normal. spi_done in the same cycle the
//   limit is reached wins (normal completion, no error).
//  Not defined: no counter; WAIT_DONE waits indefinitely; timeout_err constant 0.
// TESTING
//  1 Single req[2], req_data[2]=16'hA5C3; model returns 16'h3C5A after 40 cycles -> spi_start one pulse with
//    spi_tx_data=A5C3, grant=4'b0100 until done[2], rx_data=3C5A, busy low GAP_CYCLES+2 cycles after spi_done.
//  2 req=4'b1111 held, data 0x0001..0x0004 -> launches in order 0,1,2,3,0; exactly GAP_CYCLES idle between each.
//  3 req[1] dropped one cycle after grant -> transfer finishes, done[1] pulses once, requester 1 not re-granted.
//  4 reset asserted in WAIT_DONE -> next cycle all outputs 0, no done pulse; req[0] high afterwards wins first.
//  5 (TIMEOUT_EN, TIMEOUT_CYCLES=16) model never asserts spi_done -> done+timeout_err pulse 17 cycles after
//    launch, rx_data=0; spi_done exactly at limit -> no timeout_err, rx_data=model word.

Source files
------------

// File: rtl/spi_req_scheduler.sv
// Round-robin scheduler sharing one SPI master between NUM_REQ requesters; returns rx word and enforces CS gap.
// Latency: launch one cycle after arbitration; done pulse one cycle after spi_done; GAP_CYCLES idle before next arbitration.
// Backpressure: level req held until own done pulse; no new launch while busy. Optional macro: SPI_SCHED_TIMEOUT_EN.
module spi_req_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      busy,
    output logic                      spi_start,
    output logic [DATA_W-1:0]         spi_tx_data,
    input  logic [DATA_W-1:0]         spi_rx_data,
    input  logic                      spi_done,
    output logic                      timeout_err
);

    localparam int IDX_W    = $clog2(NUM_REQ);
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE,
        S_GAP
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W-1:0]     pick;
    logic [IDX_W-1:0]     pick_next;
    logic                 pick_vld;
    logic [DATA_W-1:0]    pick_dat;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 to_hit;
    logic                 wait_end;

    // Round-robin pick: first requesting index at or after the pointer, wrapping.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_vld && req[IDX_W'(idx)]) begin
                pick_vld = 1'b1;
                pick     = IDX_W'(idx);
            end
        end
    end

    // Word of the winning requester and the pointer value that follows it.
    always_comb begin
        pick_dat = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == pick) begin
                pick_dat = req_data[k*DATA_W +: DATA_W];
            end
        end
        pick_next = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
    end

    assign wait_end = spi_done | to_hit;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state outputs; grant spans launch through the done cycle.
    always_comb begin
        state_d   = state_q;
        grant     = '0;
        done      = '0;
        spi_start = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                spi_start     = 1'b1;
                grant[winner] = 1'b1;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                grant[winner] = 1'b1;
                if (wait_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                grant[winner] = 1'b1;
                done[winner]  = 1'b1;
                state_d       = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(GAP_LAST)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: winner/tx latch at arbitration, rx capture at completion, gap counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            winner      <= '0;
            spi_tx_data <= '0;
            rx_data     <= '0;
            gap_cnt     <= '0;
        end else begin
            if (state_q == S_IDLE && pick_vld) begin
                winner      <= pick;
                spi_tx_data <= pick_dat;
                rr_ptr      <= pick_next;
            end
            // An aborted transfer returns zero rather than whatever the bus holds.
            if (state_q == S_WAIT && wait_end) begin
                rx_data <= spi_done ? spi_rx_data : '0;
            end
            if (state_q == S_DONE) begin
                gap_cnt <= '0;
            end else if (state_q == S_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_flag;

    // A real spi_done in the limit cycle takes precedence over the abort.
    assign to_hit      = (state_q == S_WAIT) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = (state_q == S_DONE) && to_flag;

    // Cycles spent in WAIT since launch, and whether the finished transfer was aborted.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (state_q == S_LAUNCH) begin
                to_cnt <= '0;
            end else if (state_q == S_WAIT) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (state_q == S_WAIT && wait_end) begin
                to_flag <= !spi_done;
            end
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
